// File: rtl/ram_divide_pkg.sv
// ram_divide_pkg: shared constants for the RAM-backed sequential divider.
//   DataWidth / AddrWidth : datapath and RAM/ROM address widths
//   state_e               : FSM state encoding, visible on st_out
//   div_rom()             : 8-entry divisor lookup table
package ram_divide_pkg;

    localparam int unsigned DataWidth = 8;
    localparam int unsigned AddrWidth = 3;
    localparam int unsigned Depth     = 8;

    typedef enum logic [3:0] {
        StIdle = 4'd0,
        StRead = 4'd1,
        StLoad = 4'd2,
        StDiv  = 4'd3,
        StDone = 4'd4
    } state_e;

    // Entry n lives at bits [8n+7:8n]; address 0 holds the zero divisor.
    localparam logic [Depth*DataWidth-1:0] DivRomTable = {
        8'd15, 8'd10, 8'd7, 8'd5, 8'd3, 8'd2, 8'd1, 8'd0
    };

    function automatic logic [DataWidth-1:0] div_rom(input logic [AddrWidth-1:0] adr);
        return DivRomTable[{adr, 3'b000} +: DataWidth];
    endfunction

endpackage

// File: rtl/seq_div8.sv
// seq_div8: 8-bit unsigned restoring divider, one quotient bit per step, MSB first.
//   clk, rst         : clock, synchronous active-high reset
//   load             : capture dividend/divisor, clear partial remainder
//   step             : resolve the next quotient bit
//   dividend/divisor : operands sampled on load (divisor must be nonzero)
//   quotient         : valid after 8 steps
//   remainder        : valid after 8 steps
module seq_div8
    import ram_divide_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 step,
    input  logic [DataWidth-1:0] dividend,
    input  logic [DataWidth-1:0] divisor,
    output logic [DataWidth-1:0] quotient,
    output logic [DataWidth-1:0] remainder
);

    logic [DataWidth-1:0] rem_q;
    logic [DataWidth-1:0] quo_q;  // shifts dividend bits out, quotient bits in
    logic [DataWidth-1:0] dvs_q;

    // Shifted partial remainder needs the extra bit: with dividend 255 and a
    // large divisor it can reach 2*divisor-1 before the trial subtraction.
    logic [DataWidth:0]   partial;
    logic                 fits;
    logic [DataWidth-1:0] diff;
    logic [DataWidth-1:0] rem_d;

    always_comb begin
        partial = {rem_q, quo_q[DataWidth-1]};
        fits    = (partial >= {1'b0, dvs_q});
        // When it fits the true difference is below the divisor, so 8 bits suffice.
        diff    = partial[DataWidth-1:0] - dvs_q;
        rem_d   = fits ? diff : partial[DataWidth-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else if (load) begin
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
        end else if (step) begin
            rem_q <= rem_d;
            quo_q <= {quo_q[DataWidth-2:0], fits};
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/ram_divide.sv
// ram_divide: divides a RAM-resident dividend by a ROM divisor.
//   clk, rst              : clock, synchronous active-high reset (RAM not cleared)
//   start                 : request a divide, sampled in IDLE only
//   adr_ram, adr_div      : dividend RAM address, divisor ROM address
//   wr_en/wr_adr/wr_data  : external RAM write port, accepted in every state
//   quotient, remainder   : registered results, held until the next DONE
//   st_out                : FSM state code
//   busy, done, div_by_zero : status; done pulses one cycle after DONE
// Build option: define RAM_WRITEBACK_EN to write the quotient back into
// RAM[adr_ram] in DONE (an external write in the same cycle takes priority).
module ram_divide
    import ram_divide_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [AddrWidth-1:0] adr_ram,
    input  logic [AddrWidth-1:0] adr_div,
    input  logic                 wr_en,
    input  logic [AddrWidth-1:0] wr_adr,
    input  logic [DataWidth-1:0] wr_data,
    output logic [DataWidth-1:0] quotient,
    output logic [DataWidth-1:0] remainder,
    output logic [3:0]           st_out,
    output logic                 busy,
    output logic                 done,
    output logic                 div_by_zero
);

    logic [DataWidth-1:0] ram [Depth];

    state_e               state_q;
    logic [AddrWidth-1:0] adr_ram_q;
    logic [AddrWidth-1:0] adr_div_q;
    logic [DataWidth-1:0] dividend_q;
    logic [DataWidth-1:0] divisor_q;
    logic [2:0]           step_cnt_q;
    logic [DataWidth-1:0] quotient_q;
    logic [DataWidth-1:0] remainder_q;
    logic                 dz_q;
    logic                 done_q;

    logic                 div_load;
    logic                 div_step;
    logic [DataWidth-1:0] div_quotient;
    logic [DataWidth-1:0] div_remainder;
    logic                 dz_now;
    logic [DataWidth-1:0] res_quotient;
    logic [DataWidth-1:0] res_remainder;

    always_comb begin
        div_load      = (state_q == StLoad);
        div_step      = (state_q == StDiv);
        dz_now        = (divisor_q == '0);
        res_quotient  = dz_now ? {DataWidth{1'b1}} : div_quotient;
        res_remainder = dz_now ? dividend_q : div_remainder;
    end

    seq_div8 u_seq_div8 (
        .clk       (clk),
        .rst       (rst),
        .load      (div_load),
        .step      (div_step),
        .dividend  (dividend_q),
        .divisor   (divisor_q),
        .quotient  (div_quotient),
        .remainder (div_remainder)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            adr_ram_q   <= '0;
            adr_div_q   <= '0;
            dividend_q  <= '0;
            divisor_q   <= '0;
            step_cnt_q  <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dz_q        <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        adr_ram_q <= adr_ram;
                        adr_div_q <= adr_div;
                        state_q   <= StRead;
                    end
                end
                StRead: begin
                    // Nonblocking read sees the RAM before any same-edge write.
                    dividend_q <= ram[adr_ram_q];
                    divisor_q  <= div_rom(adr_div_q);
                    state_q    <= StLoad;
                end
                StLoad: begin
                    step_cnt_q <= '0;
                    state_q    <= dz_now ? StDone : StDiv;
                end
                StDiv: begin
                    step_cnt_q <= step_cnt_q + 3'd1;
                    if (step_cnt_q == 3'd7) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    quotient_q  <= res_quotient;
                    remainder_q <= res_remainder;
                    dz_q        <= dz_now;
                    done_q      <= 1'b1;
                    state_q     <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // RAM is deliberately outside the reset domain so contents survive rst.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            ram[wr_adr] <= wr_data;
        end
`ifdef RAM_WRITEBACK_EN
        else if (!rst && state_q == StDone) begin
            ram[adr_ram_q] <= res_quotient;
        end
`endif
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign st_out      = state_q;
    assign busy        = (state_q != StIdle);
    assign done        = done_q;
    assign div_by_zero = dz_q;

endmodule

// File: doc/ram_divide.md
RAM_DIVIDE -- requirements
Module: ram_divide

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port start, input, 1 bit: request one divide; sampled in IDLE only.
REQ-004 SHALL have port adr_ram, input, 3 bits: RAM address of the dividend (a stored product).
REQ-005 SHALL have port adr_div, input, 3 bits: divisor ROM address.
REQ-006 SHALL have port wr_en, input, 1 bit: external RAM write strobe.
REQ-007 SHALL have port wr_adr, input, 3 bits: external RAM write address.
REQ-008 SHALL have port wr_data, input, 8 bits: external RAM write data.
REQ-009 SHALL have port quotient, output, 8 bits: registered result.
REQ-010 SHALL have port remainder, output, 8 bits: registered result.
REQ-011 SHALL have port st_out, output, 4 bits: current FSM state code.
REQ-012 SHALL have ports busy, done and div_by_zero, each output, 1 bit: status flags.

Function
REQ-013 SHALL hold an 8x8 RAM with a synchronous write, and an 8x8 divisor ROM containing {0,1,2,3,5,7,10,15} at addresses 0..7.
REQ-014 SHALL implement FSM states IDLE=0, READ=1, LOAD=2, DIV=3, DONE=4 on st_out; all other codes are unreachable and SHALL return to IDLE.
REQ-015 IDLE with start=1 SHALL latch adr_ram/adr_div and go to READ; start in any other state SHALL be ignored.
REQ-016 READ SHALL register RAM[adr_ram] and ROM[adr_div] and go to LOAD; a same-cycle external write to the same address SHALL NOT affect the value read (read-first).
REQ-017 LOAD with divisor=0 SHALL go to DONE with quotient=8'hFF, remainder=dividend, div_by_zero=1.
REQ-018 LOAD with divisor!=0 SHALL initialise an 8-bit restoring divider and go to DIV.
REQ-019 DIV SHALL resolve one quotient bit per cycle, MSB first, for exactly 8 cycles, then go to DONE.
REQ-020 Arithmetic: unsigned; the partial remainder SHALL be 9 bits wide so that no overflow occurs at dividend 255.
REQ-021 DONE SHALL update quotient/remainder, pulse done for exactly one cycle, and go to IDLE.
REQ-022 Latency: done SHALL be high 11 cycles after the start-sampling edge; in the divide-by-zero case it SHALL be high 3 cycles after.
REQ-023 busy SHALL be 1 in READ, LOAD, DIV and DONE, and 0 in IDLE.
REQ-024 quotient, remainder and div_by_zero SHALL hold until the next DONE.
REQ-025 External RAM writes SHALL be accepted in every state.

Reset
REQ-026 rst SHALL force IDLE, quotient=0, remainder=0, done=0, busy=0 and div_by_zero=0 on the next edge, including mid-divide.
REQ-027 RAM contents SHALL NOT be cleared by rst.

Configuration
REQ-028 With RAM_WRITEBACK_EN defined, DONE SHALL write quotient into RAM[latched adr_ram]; an external write in the same cycle SHALL win and the writeback SHALL be dropped.
REQ-029 Without RAM_WRITEBACK_EN, the RAM SHALL be written only by the external port.

Structure
REQ-030 A shared package SHALL hold the state encoding constants, the data width (8), the address width (3) and the divisor ROM table.
REQ-031 The divider datapath SHALL be a sub-module named seq_div8 (load, step, quotient, remainder); the FSM, RAM and ROM SHALL stay in ram_divide.

Verification
REQ-032 Write RAM[5]=200, start with adr_ram=5, adr_div=3 -> done 11 cycles later; quotient=66, remainder=2, div_by_zero=0.
REQ-033 RAM[7]=255, adr_div=1 -> quotient=255, remainder=0; adr_div=6 -> quotient=25, remainder=5.
REQ-034 RAM[2]=40, adr_div=0 -> done 3 cycles after start; quotient=8'hFF, remainder=40, div_by_zero=1.
REQ-035 Assert rst during DIV -> next cycle st_out=0, busy=0, outputs=0; a new start completes normally with RAM data intact.
REQ-036 Start held high throughout a divide -> no restart until IDLE; write RAM[5]=9 during READ of address 5 -> old value used.
REQ-037 With RAM_WRITEBACK_EN: 200/3 -> RAM[5]=66 after DONE; with wr_en to address 5 in DONE -> RAM[5]=wr_data.
